// File: rtl/irq_request_latch_if.sv
// Consumer-side handshake of irq_request_latch: masked pending vector (encoder D),
// valid, and the acknowledge carrying the encoder index back.
interface irq_request_latch_if #(
   parameter int N     = 8,
   parameter int IDX_W = 3
);
   logic [N-1:0]     pending_out;
   logic             irq_valid;
   logic             irq_ack;
   logic [IDX_W-1:0] ack_idx;

   modport master (output pending_out, irq_valid, input  irq_ack, ack_idx);
   modport slave  (input  pending_out, irq_valid, output irq_ack, ack_idx);
endinterface

// File: rtl/irq_request_latch.sv
// Request-capture stage ahead of the 8-to-3 priority encoder: synchronise, detect, latch, offer.
// Optional lost-event counter enabled by defining IRQ_LOST_CNT_EN.
module irq_request_latch #(
   parameter int N           = 8,
   parameter int IDX_W       = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0]        req_in,
   input  logic [N-1:0]        trig_edge,
   input  logic [N-1:0]        mask,
   input  logic                clear_all,
   irq_request_latch_if.master irq_if,
   output logic [15:0]         lost_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OFFER   = 2'd1,
      HOLDOFF = 2'd2
   } state_e;

   logic [N-1:0] sync_q [SYNC_STAGES];
   logic [N-1:0] sync_d [SYNC_STAGES];
   logic [N-1:0] prev_q, prev_d;
   logic [N-1:0] pending_q, pending_d;
   logic [N-1:0] sync_s, set_vec, clr_vec, pend_vis;
   state_e       state_q, state_d;
   logic         irq_valid_q, irq_valid_d;
   logic         ack_fire;

   always_comb begin
      sync_d[0] = req_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];
   assign prev_d = sync_s;

   // Edge lines fire once on a rising synchronised input; level lines fire every cycle they are high.
   assign set_vec  = sync_s & (~trig_edge | ~prev_q);
   assign pend_vis = pending_q & mask;

   always_comb begin
      clr_vec = '0;
      if (clear_all) begin
         clr_vec = '1;
      end else if (ack_fire && (32'(irq_if.ack_idx) < N)) begin
         clr_vec[irq_if.ack_idx] = 1'b1;
      end
   end

   // OR-ing set_vec after the clear makes a coincident set win over ack or clear_all.
   assign pending_d = (pending_q & ~clr_vec) | set_vec;

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      ack_fire = 1'b0;
      unique case (state_q)
         IDLE: begin
            if ((|pend_vis) && !clear_all) state_d = OFFER;
         end
         OFFER: begin
            if (irq_if.irq_ack) begin
               ack_fire = 1'b1;
               state_d  = HOLDOFF;
            end else if (clear_all || !(|pend_vis)) begin
               state_d = IDLE;
            end
         end
         HOLDOFF: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      irq_valid_d = (state_d == OFFER);
   end

   // NOTE: sequential state uses non-blocking assignments only; the synchroniser array is
   // reset element by element because it is real flops, not a RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q      <= '0;
         pending_q   <= '0;
         state_q     <= IDLE;
         irq_valid_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         prev_q      <= prev_d;
         pending_q   <= pending_d;
         state_q     <= state_d;
         irq_valid_q <= irq_valid_d;
      end
   end

   assign irq_if.pending_out = pend_vis;
   assign irq_if.irq_valid   = irq_valid_q;

`ifdef IRQ_LOST_CNT_EN
   logic [15:0] lost_q, lost_d;
   logic        lost_evt;

   // A lost event is a fresh edge on a line whose previous event is still pending.
   always_comb begin
      lost_evt = |(set_vec & trig_edge & pending_q & ~clr_vec);
      lost_d   = lost_q;
      if (clear_all) begin
         lost_d = '0;
      end else if (lost_evt && (lost_q != 16'hFFFF)) begin
         lost_d = lost_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lost_q <= '0;
      else        lost_q <= lost_d;
   end

   assign lost_cnt = lost_q;
`else
   assign lost_cnt = 16'h0000;
`endif

endmodule
